mux_arbiter: RTL and testbench
==============================

// Module: mux_arbiter
// PURPOSE
//  - Round-robin arbiter that lets two requesters (A, B) share one 1-bit datapath:
//    a 2:1 mux (sel) feeding a registered output.
//  - Grants the path in bursts of BURST_LEN cycles, drives sel, and gates/registers the mux output.
//  - Sits directly in front of the existing mux2x1/or_base datapath; replaces the free-running sel input.
// PARAMETERS
//  - BURST_LEN  4  cycles a grant is held (>=1)
//  - CNT_W      2  burst counter width; 2**CNT_W >= BURST_LEN required
// PORTS
//  - clk    in   1  rising-edge clock
//  - rst    in   1  synchronous reset, active-high
//  - req_a  in   1  requester A wants the path
//  - req_b  in   1  requester B wants the path
//  - a      in   1  data from A (mux input 0)
//  - b      in   1  data from B (mux input 1)
//  - gnt_a  out  1  A owns the path (registered)
//  - gnt_b  out  1  B owns the path (registered)
//  - sel    out  1  mux select; equals gnt_b (0 when idle)
//  - op     out  1  registered path output: (gnt_a&a)|(gnt_b&b) of previous cycle
//  - busy   out  1  gnt_a|gnt_b
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, gnt_a=gnt_b=0, sel=0, op=0, busy=0, cnt=0, last=B (A wins first).
//  - FSM states: IDLE, GNT_A, GNT_B; gnt_a/gnt_b are one-hot decodes of state, never both 1.
//  - IDLE: req_a&~req_b -> GNT_A; req_b&~req_a -> GNT_B; both -> side opposite to last; none -> stay.
//    Latency: req sampled at edge N, gnt visible after edge N (1 cycle), data on op after edge N+1.
//  - GNT_x: cnt increments each cycle from 0; on edge with cnt==BURST_LEN-1:
//    other req=1 -> switch straight to other GNT (no idle bubble), cnt=0, last=x;
//    else own req=1 -> re-grant x, cnt=0; else -> IDLE, last=x.
//  - BURST_LEN=1: arbitration every cycle; alternates when both request.
//  - Requests dropped mid-burst: grant still held to burst end (see CONFIGURATION).
//  - op registered each cycle from current gnt and inputs; op=0 in cycles following IDLE.
//  - rst mid-burst: grant drops at that edge, op=0, last=B, as full reset.
//  - cnt never wraps: reloaded to 0 at every grant change/re-grant.
// CONFIGURATION
//  - Macro MUX_ARB_EARLY_RELEASE_EN.
//  - Defined: in GNT_x with own req=0 at an edge, leave burst immediately:
//    other req -> other GNT, else IDLE; last=x, cnt=0.
//  - Undefined: grant held for all BURST_LEN cycles regardless of own req.
// STRUCTURE
//  - Shared include mux_arb_defs.vh: state localparams ST_IDLE=2'd0, ST_GNT_A=2'd1, ST_GNT_B=2'd2,
//    state width 2; also used by bench for state checks.
//  - Sub-module: existing mux2x1 instanced for the data mux (.a(a), .b(b), .sel(sel)).
//    Gating and op register stay in this module.
// TESTING
//  - Reset: rst=1 two cycles with req_a=req_b=1
//    -> gnt_a=gnt_b=sel=op=busy=0; first grant after release is A.
//  - Single: req_a=1 held, a=1, BURST_LEN=4
//    -> gnt_a=1 one cycle later, continuous (re-grant), op=1 from next cycle, sel=0.
//  - Contention: req_a=req_b=1 from reset release -> gnt_a cycles 1-4, gnt_b cycles 5-8, gnt_a 9-12;
//    no idle bubble; sel=1 exactly in B cycles.
//  - Data path: in GNT_B with a=0, b toggling -> op follows b one cycle delayed; a ignored.
//  - Mid-burst reset: rst=1 at cnt=2 of GNT_B -> next cycle idle, op=0;
//    with both req, A granted next.
//  - Early release: GNT_A, drop req_a at cnt=1, req_b=1 -> with macro gnt_b next cycle;
//    without macro gnt_b after cnt=3.

Source files
------------

// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg: state encoding and helpers shared by the arbiter RTL and its bench.
package mux_arbiter_pkg;
    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } state_t;

    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    function automatic state_t other_grant(input state_t s);
        return (s == ST_GNT_B) ? ST_GNT_A : ST_GNT_B;
    endfunction
endpackage

// File: rtl/mux2x1.sv
// mux2x1: existing 1-bit 2:1 datapath mux (sel=0 -> a, sel=1 -> b).
module mux2x1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin burst arbiter driving a mux2x1 select with a registered, gated output.
// Optional MUX_ARB_EARLY_RELEASE_EN lets a grant end as soon as its owner drops its request.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic a,
    input  logic b,
    output logic gnt_a,
    output logic gnt_b,
    output logic sel,
    output logic op,
    output logic busy
);
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             last, last_n;
    logic             mux_y;
    logic             own_req, other_req, burst_end;

    assign gnt_a = (state == ST_GNT_A);
    assign gnt_b = (state == ST_GNT_B);
    assign sel   = gnt_b;
    assign busy  = gnt_a | gnt_b;

    mux2x1 u_mux (.a(a), .b(b), .sel(sel), .y(mux_y));

    assign own_req   = gnt_b ? req_b : req_a;
    assign other_req = gnt_b ? req_a : req_b;
    assign burst_end = (cnt == CNT_W'(BURST_LEN - 1));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last;
        if (state == ST_IDLE) begin
            // On contention the side that did not own the path last wins.
            if (req_a && (!req_b || last == LAST_B)) begin
                state_n = ST_GNT_A;
                cnt_n   = '0;
            end else if (req_b) begin
                state_n = ST_GNT_B;
                cnt_n   = '0;
            end
        end else begin
`ifdef MUX_ARB_EARLY_RELEASE_EN
            if (!own_req) begin
                state_n = other_req ? other_grant(state) : ST_IDLE;
                cnt_n   = '0;
                last_n  = gnt_b ? LAST_B : LAST_A;
            end else if (burst_end) begin
`else
            if (burst_end) begin
`endif
                cnt_n = '0;
                if (other_req) begin
                    state_n = other_grant(state);
                    last_n  = gnt_b ? LAST_B : LAST_A;
                end else if (!own_req) begin
                    state_n = ST_IDLE;
                    last_n  = gnt_b ? LAST_B : LAST_A;
                end
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            last  <= LAST_B;
            op    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            last  <= last_n;
            op    <= busy & mux_y;
        end
    end
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed checks of reset, bursts, contention, datapath, mid-burst reset, release.
module tb_mux_arbiter;
    import mux_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_a = 1'b0, req_b = 1'b0, a = 1'b0, b = 1'b0;
    logic gnt_a, gnt_b, sel, op, busy;
    int   tests = 0;
    int   errs  = 0;

    mux_arbiter dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .op(op), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_a = 1'b1; req_b = 1'b1; a = 1'b1; b = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if ({gnt_a, gnt_b, sel, op, busy} !== 5'b0) begin
                errs++;
                $display("FAIL reset[%0d] gnt_a,gnt_b,sel,op,busy=%b expected 00000", i, {gnt_a, gnt_b, sel, op, busy});
            end
        end
        rst = 1'b0;
        tick();
        tests++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            errs++;
            $display("FAIL reset_first_grant gnt_a,gnt_b=%b expected 10", {gnt_a, gnt_b});
        end
    endtask

    task automatic test_single();
        req_a = 1'b0; req_b = 1'b0; a = 1'b1; b = 1'b0;
        do_reset();
        req_a = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            tests++;
            if ({gnt_a, gnt_b, sel, op} !== {2'b10, 1'b0, i >= 2}) begin
                errs++;
                $display("FAIL single[%0d] gnt_a,gnt_b,sel,op=%b expected %b", i, {gnt_a, gnt_b, sel, op}, {2'b10, 1'b0, i >= 2});
            end
        end
    endtask

    task automatic test_contention();
        logic eb;
        req_a = 1'b1; req_b = 1'b1; a = 1'b0; b = 1'b0;
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            tick();
            eb = (i >= 5 && i <= 8);
            tests++;
            if ({gnt_a, gnt_b, sel, busy} !== {~eb, eb, eb, 1'b1}) begin
                errs++;
                $display("FAIL contention[%0d] gnt_a,gnt_b,sel,busy=%b expected %b", i, {gnt_a, gnt_b, sel, busy}, {~eb, eb, eb, 1'b1});
            end
        end
    endtask

    task automatic test_datapath();
        logic [7:0] pat;
        pat = 8'b1011_0010;
        req_a = 1'b0; req_b = 1'b1; a = 1'b0; b = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 8; i++) begin
            b = pat[i];
            a = ~pat[i];
            tick();
            tests++;
            if ({gnt_b, sel, op} !== {2'b11, pat[i]}) begin
                errs++;
                $display("FAIL datapath[%0d] gnt_b,sel,op=%b expected %b", i, {gnt_b, sel, op}, {2'b11, pat[i]});
            end
        end
    endtask

    task automatic test_mid_reset();
        req_a = 1'b0; req_b = 1'b1; a = 1'b1; b = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        tests++;
        if (dut.state !== ST_GNT_B || dut.cnt !== 2'd2) begin
            errs++;
            $display("FAIL mid_reset_setup state=%0d cnt=%0d expected state=%0d cnt=2", dut.state, dut.cnt, ST_GNT_B);
        end
        req_a = 1'b1;
        rst = 1'b1;
        tick();
        tests++;
        if ({gnt_a, gnt_b, op, busy} !== 4'b0) begin
            errs++;
            $display("FAIL mid_reset_idle gnt_a,gnt_b,op,busy=%b expected 0000", {gnt_a, gnt_b, op, busy});
        end
        rst = 1'b0;
        tick();
        tests++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            errs++;
            $display("FAIL mid_reset_regrant gnt_a,gnt_b=%b expected 10", {gnt_a, gnt_b});
        end
    endtask

    task automatic test_early_release();
        int  first_b;
        logic eb;
`ifdef MUX_ARB_EARLY_RELEASE_EN
        first_b = 1;
`else
        first_b = 3;
`endif
        req_a = 1'b1; req_b = 1'b0; a = 1'b0; b = 1'b0;
        do_reset();
        tick();
        tick();
        req_a = 1'b0;
        req_b = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            eb = (k >= first_b);
            tests++;
            if ({gnt_a, gnt_b} !== {~eb, eb}) begin
                errs++;
                $display("FAIL early_release[%0d] gnt_a,gnt_b=%b expected %b", k, {gnt_a, gnt_b}, {~eb, eb});
            end
        end
    endtask

    task automatic test_burst_end_idle();
        int   hold;
        logic eg, eo;
`ifdef MUX_ARB_EARLY_RELEASE_EN
        hold = 1;
`else
        hold = 4;
`endif
        req_a = 1'b1; req_b = 1'b0; a = 1'b1; b = 1'b0;
        do_reset();
        for (int i = 1; i <= hold + 2; i++) begin
            tick();
            req_a = 1'b0;
            eg = (i <= hold);
            eo = (i >= 2 && i <= hold + 1);
            tests++;
            if ({gnt_a, busy, op} !== {eg, eg, eo}) begin
                errs++;
                $display("FAIL burst_end_idle[%0d] gnt_a,busy,op=%b expected %b", i, {gnt_a, busy, op}, {eg, eg, eo});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_datapath();
        test_mid_reset();
        test_early_release();
        test_burst_end_idle();
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
